// File: rtl/mips_multicycle_core_if.sv
// Shared instruction/data memory port for the multi-cycle MIPS core.
// The core drives the master side (req/we/addr/wdata); memory drives rdata/ack.
interface mips_multicycle_core_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic [31:0]           rdata;
    logic                  ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS32 integer core (add/sub/and/or/slt, addi, lw, sw, beq, j) on one req/ack memory port.
// Define MIPS_MC_ILLEGAL_TRAP_EN to halt on illegal opcodes/functs; otherwise they retire as NOPs.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    mips_multicycle_core_if.master mem,
    output logic [31:0]            pc_o,
    output logic                   instr_retired,
    output logic                   halted
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        S_START,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_WB_R,
        S_EXEC_I,
        S_WB_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_WB_MEM,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP,
        S_ILLEGAL,
        S_HALT
    } state_t;

    state_t state, state_next;

    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] alu_out;
    logic [31:0] regs [32];

    logic [5:0]         op;
    logic [5:0]         funct;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic [4:0]         rd;
    logic signed [31:0] imm_sext;
    logic [25:0]        target;
    logic [31:0]        rs_val;
    logic [31:0]        rt_val;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        retire;

    function automatic logic funct_legal(input logic [5:0] fn);
        funct_legal = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                      (fn == FN_OR)  || (fn == FN_SLT);
    endfunction

    // All arithmetic wraps; slt compares as two's complement.
    function automatic logic [31:0] alu_r(input logic [31:0] x, input logic [31:0] y,
                                          input logic [5:0] fn);
        logic signed [31:0] xs;
        logic signed [31:0] ys;
        xs    = $signed(x);
        ys    = $signed(y);
        alu_r = 32'd0;
        case (fn)
            FN_ADD:  alu_r = x + y;
            FN_SUB:  alu_r = x - y;
            FN_AND:  alu_r = x & y;
            FN_OR:   alu_r = x | y;
            FN_SLT:  alu_r = {31'd0, (xs < ys)};
            default: alu_r = 32'd0;
        endcase
    endfunction

    assign op       = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign target   = ir[25:0];
    assign imm_sext = {{16{ir[15]}}, ir[15:0]};

    assign rs_val = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign rt_val = (rt == 5'd0) ? 32'd0 : regs[rt];

    assign pc_o          = pc;
    assign instr_retired = retire;

`ifdef MIPS_MC_ILLEGAL_TRAP_EN
    assign halted = (state == S_HALT);
`else
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_START;
        end else begin
            state <= state_next;
        end
    end

    // Bus outputs are pure decodes of state and registers, so they hold steady across wait states.
    always_comb begin
        state_next = state;
        mem.req    = 1'b0;
        mem.we     = 1'b0;
        mem.addr   = '0;
        mem.wdata  = 32'd0;
        retire     = 1'b0;
        case (state)
            S_START: state_next = S_FETCH;
            S_FETCH: begin
                mem.req  = 1'b1;
                mem.addr = pc[ADDR_WIDTH-1:0];
                if (mem.ack) state_next = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_RTYPE:     state_next = S_EXEC_R;
                    OP_ADDI:      state_next = S_EXEC_I;
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    default:      state_next = S_ILLEGAL;
                endcase
            end
            S_EXEC_R: state_next = funct_legal(funct) ? S_WB_R : S_ILLEGAL;
            S_WB_R: begin
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_EXEC_I: state_next = S_WB_I;
            S_WB_I: begin
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_ADDR: state_next = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                mem.req  = 1'b1;
                mem.addr = alu_out[ADDR_WIDTH-1:0];
                if (mem.ack) state_next = S_WB_MEM;
            end
            S_WB_MEM: begin
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WR: begin
                mem.req   = 1'b1;
                mem.we    = 1'b1;
                mem.addr  = alu_out[ADDR_WIDTH-1:0];
                mem.wdata = b_reg;
                if (mem.ack) begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_BRANCH, S_JUMP: begin
                retire     = 1'b1;
                state_next = S_FETCH;
            end
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
            S_ILLEGAL: state_next = S_HALT;
            S_HALT:    state_next = S_HALT;
`else
            S_ILLEGAL: begin
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT: state_next = S_FETCH;
`endif
            default: state_next = S_START;
        endcase
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = alu_out;
        case (state)
            S_WB_R: begin
                rf_we    = 1'b1;
                rf_waddr = rd;
            end
            S_WB_I: begin
                rf_we    = 1'b1;
                rf_waddr = rt;
            end
            S_WB_MEM: begin
                rf_we    = 1'b1;
                rf_waddr = rt;
                rf_wdata = mdr;
            end
            default: rf_we = 1'b0;
        endcase
    end

    // pc already points past the instruction when BRANCH/JUMP run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= RESET_PC;
            ir      <= 32'd0;
            mdr     <= 32'd0;
            a_reg   <= 32'd0;
            b_reg   <= 32'd0;
            alu_out <= 32'd0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem.ack) begin
                        ir <= mem.rdata;
                        pc <= pc + 32'd4;
                    end
                end
                S_DECODE: begin
                    a_reg <= rs_val;
                    b_reg <= rt_val;
                end
                S_EXEC_R:             alu_out <= alu_r(a_reg, b_reg, funct);
                S_EXEC_I, S_MEM_ADDR: alu_out <= a_reg + imm_sext;
                S_MEM_RD: begin
                    if (mem.ack) mdr <= mem.rdata;
                end
                S_BRANCH: begin
                    if (a_reg == b_reg) pc <= pc + {imm_sext[29:0], 2'b00};
                end
                S_JUMP:  pc <= {pc[31:28], target, 2'b00};
                default: pc <= pc;
            endcase
            if (rf_we && (rf_waddr != 5'd0)) regs[rf_waddr] <= rf_wdata;
        end
    end

endmodule
